// File: rtl/alu_exec_ctrl.sv
// Execute-stage ALU controller and datapath.
// Decodes alu_op/funct and produces single-cycle results. MULT/MULTU run as
// iterative shift-add over DATA_W cycles into internal HI/LO.
// Build option ALU_DIV_EN: when defined, DIV/DIVU run as an iterative restoring
// divider with the same latency. When undefined, they complete in one cycle and
// leave HI/LO untouched.
module alu_exec_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [3:0]        operation,
  output logic              out_valid,
  output logic              out_wb,
  output logic [DATA_W-1:0] result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
`ifdef ALU_DIV_EN
  localparam logic [1:0] ST_DIV  = 2'd2;
`endif

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;

  // Unknown funct codes fall back to slt, matching the legacy decoder.
  function automatic logic [3:0] decode_op(input logic [1:0] aop, input logic [5:0] fn);
    logic [3:0] code;
    case (aop)
      2'b00:   code = OP_ADD;
      2'b01:   code = OP_SUB;
      2'b11:   code = OP_SLT;
      default: begin
        case (fn)
          6'b000000, 6'b100000: code = OP_ADD;
          6'b100010:            code = OP_SUB;
          6'b100100:            code = OP_AND;
          6'b100101:            code = OP_OR;
          6'b101010:            code = OP_SLT;
          6'b100111:            code = OP_NOR;
          6'b011000, 6'b011001: code = OP_MUL;
          6'b011010, 6'b011011: code = OP_DIV;
          6'b010000:            code = OP_MFHI;
          6'b010010:            code = OP_MFLO;
          default:              code = OP_SLT;
        endcase
      end
    endcase
    return code;
  endfunction

  function automatic logic [DATA_W-1:0] alu_calc(input logic [3:0] code,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] hi_v,
                                                 input logic [DATA_W-1:0] lo_v);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [DATA_W-1:0]        r;
    sa = signed'(a);
    sb = signed'(b);
    case (code)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_MFHI: r = hi_v;
      OP_MFLO: r = lo_v;
      default: r = {{(DATA_W-1){1'b0}}, (sa < sb)};
    endcase
    return r;
  endfunction

  // Magnitude for signed ops; unsigned ops pass the raw value through.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   acc_hi;
  logic [DATA_W-1:0]   acc_lo;
  logic [DATA_W-1:0]   mcand;
  logic                sign_q;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;

  logic [3:0]          dec_op;
  logic                is_signed;
  logic                neg_a;
  logic                neg_b;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   mul_hi_nx;
  logic [DATA_W-1:0]   mul_lo_nx;
  logic [2*DATA_W-1:0] prod_raw;
  logic [2*DATA_W-1:0] prod;

  assign in_ready  = (state == ST_IDLE);
  assign dec_op    = decode_op(alu_op, funct);
  assign is_signed = ~funct[0];
  assign neg_a     = is_signed & op_a[DATA_W-1];
  assign neg_b     = is_signed & op_b[DATA_W-1];

  // One shift-add step: conditionally add multiplicand into the high half, then shift right.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(DATA_W+1){1'b0}});
    mul_hi_nx = mul_sum[DATA_W:1];
    mul_lo_nx = {mul_sum[0], acc_lo[DATA_W-1:1]};
    prod_raw  = {mul_hi_nx, mul_lo_nx};
    prod      = sign_q ? (~prod_raw + 1'b1) : prod_raw;
  end

`ifdef ALU_DIV_EN
  logic                sign_r;
  logic                div_zero;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic                div_ge;
  logic [DATA_W-1:0]   div_hi_nx;
  logic [DATA_W-1:0]   div_lo_nx;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;

  // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    div_shift = {acc_hi, acc_lo[DATA_W-1]};
    div_diff  = div_shift - {1'b0, mcand};
    div_ge    = (div_shift >= {1'b0, mcand});
    div_hi_nx = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
    div_lo_nx = {acc_lo[DATA_W-2:0], div_ge};
    quo       = sign_q ? (~div_lo_nx + 1'b1) : div_lo_nx;
    rem       = sign_r ? (~div_hi_nx + 1'b1) : div_hi_nx;
  end
`endif

  // Control FSM, iterative datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      mcand     <= '0;
      sign_q    <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      operation <= 4'b0000;
      out_valid <= 1'b0;
      out_wb    <= 1'b0;
      result    <= '0;
`ifdef ALU_DIV_EN
      sign_r    <= 1'b0;
      div_zero  <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!flush && in_valid) begin
            operation <= dec_op;
            if (dec_op == OP_MUL) begin
              acc_hi <= '0;
              acc_lo <= mag(op_a, is_signed);
              mcand  <= mag(op_b, is_signed);
              sign_q <= neg_a ^ neg_b;
              cnt    <= CNT_W'(DATA_W-1);
              out_wb <= 1'b0;
              state  <= ST_MUL;
            end else if (dec_op == OP_DIV) begin
`ifdef ALU_DIV_EN
              acc_hi   <= (op_b == '0) ? op_a : '0;
              acc_lo   <= mag(op_a, is_signed);
              mcand    <= mag(op_b, is_signed);
              sign_q   <= neg_a ^ neg_b;
              sign_r   <= neg_a;
              div_zero <= (op_b == '0);
              cnt      <= CNT_W'(DATA_W-1);
              out_wb   <= 1'b0;
              state    <= ST_DIV;
`else
              result    <= lo;
              out_valid <= 1'b1;
              out_wb    <= 1'b0;
`endif
            end else begin
              result    <= alu_calc(dec_op, op_a, op_b, hi, lo);
              out_valid <= 1'b1;
              out_wb    <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            acc_hi <= mul_hi_nx;
            acc_lo <= mul_lo_nx;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              hi        <= prod[2*DATA_W-1:DATA_W];
              lo        <= prod[DATA_W-1:0];
              result    <= prod[DATA_W-1:0];
              out_valid <= 1'b1;
              out_wb    <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
`ifdef ALU_DIV_EN
        ST_DIV: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            if (!div_zero) begin
              acc_hi <= div_hi_nx;
              acc_lo <= div_lo_nx;
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              hi        <= div_zero ? acc_hi : rem;
              lo        <= div_zero ? {DATA_W{1'b1}} : quo;
              result    <= div_zero ? {DATA_W{1'b1}} : quo;
              out_valid <= 1'b1;
              out_wb    <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl (DATA_W=32); DIV checks follow ALU_DIV_EN.
module tb_alu_exec_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  operation;
  logic        out_valid;
  logic        out_wb;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  alu_exec_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
    .operation(operation), .out_valid(out_valid), .out_wb(out_wb), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aop;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one accepting edge.
  task automatic issue(input logic [1:0] aop, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    alu_op = aop; funct = fn; op_a = a; op_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until the result strobe, bounded.
  task automatic wait_strobe(input string name, input int expect_cycles);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no out_valid after %0d cycles, required %0d", name, n, expect_cycles);
    end else begin
      chk({name, "_latency"}, 64'(n), 64'(expect_cycles));
    end
  endtask

  task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(2'b10, 6'b010000, 32'h0, 32'h0);
    chk({name, "_mfhi"}, 64'(result), 64'(exp_hi));
    chk({name, "_mfhi_op"}, 64'(operation), 64'(4'b1010));
    issue(2'b10, 6'b010010, 32'h0, 32'h0);
    chk({name, "_mflo"}, 64'(result), 64'(exp_lo));
  endtask

  // Run a long op and check its completion strobe.
  task automatic long_op(input string name, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] code,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(2'b10, fn, a, b);
    chk({name, "_busy"}, {62'h0, in_ready, out_valid}, 64'h0);
    wait_strobe(name, 32);
    chk({name, "_res"}, 64'(result), 64'(exp_lo));
    chk({name, "_wb_op"}, {59'h0, out_wb, operation}, {59'h0, 1'b0, code});
    chk({name, "_ready"}, 64'(in_ready), 64'h1);
    read_hilo(name, exp_hi, exp_lo);
  endtask

  initial begin
    int bad;
    vecs[0]  = '{2'b10, 6'b100010, 32'h5,        32'h7,        32'hFFFFFFFE, 4'b0110};
    vecs[1]  = '{2'b10, 6'b111111, 32'hFFFFFFFF, 32'h0,        32'h00000001, 4'b0111};
    vecs[2]  = '{2'b00, 6'b000000, 32'hFFFFFFFF, 32'h1,        32'h00000000, 4'b0010};
    vecs[3]  = '{2'b01, 6'b000000, 32'h0,        32'h1,        32'hFFFFFFFF, 4'b0110};
    vecs[4]  = '{2'b11, 6'b000000, 32'h7,        32'hFFFFFFF9, 32'h00000000, 4'b0111};
    vecs[5]  = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0000};
    vecs[6]  = '{2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 4'b0001};
    vecs[7]  = '{2'b10, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 4'b1100};
    vecs[8]  = '{2'b10, 6'b000000, 32'h3,        32'h4,        32'h00000007, 4'b0010};
    vecs[9]  = '{2'b10, 6'b100000, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0010};
    vecs[10] = '{2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 4'b0111};
    vecs[11] = '{2'b10, 6'b010000, 32'h12345678, 32'h1,        32'h00000000, 4'b1010};
    vecs[12] = '{2'b10, 6'b010010, 32'h12345678, 32'h1,        32'h00000000, 4'b1011};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    alu_op = 2'b00; funct = 6'h0; op_a = 32'h0; op_b = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_ready", 64'(in_ready), 64'h1);
    chk("reset_outs", {27'h0, out_valid, out_wb, operation, result},
        {27'h0, 1'b0, 1'b0, 4'b0000, 32'h0});

    // Back-to-back single-cycle ops, one accept per edge.
    for (int i = 0; i < 13; i++) begin
      alu_op = vecs[i].aop; funct = vecs[i].fn; op_a = vecs[i].a; op_b = vecs[i].b;
      in_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d_res", i), 64'(result), 64'(vecs[i].res));
      chk($sformatf("vec%0d_op", i), 64'(operation), 64'(vecs[i].code));
      chk($sformatf("vec%0d_strobe", i), {62'h0, out_valid, out_wb}, 64'h3);
    end
    in_valid = 1'b0;

    // Idle: strobe drops, result/operation hold.
    tick();
    chk("idle_hold", {27'h0, out_valid, operation, result}, {27'h0, 1'b0, 4'b1011, 32'h0});

    // Flush in IDLE drops the input.
    flush = 1'b1;
    issue(2'b00, 6'h0, 32'h11, 32'h22);
    flush = 1'b0;
    chk("flush_idle", {27'h0, out_valid, operation, result}, {27'h0, 1'b0, 4'b1011, 32'h0});

    // Signed and unsigned multiplies.
    long_op("mult", 6'b011000, 32'hFFFFFFFD, 32'h7, 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFEB);
    long_op("multu", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 32'hFFFFFFFE, 32'h00000001);
    long_op("mult_mm", 6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 32'h00000000, 32'h00000001);

    // Async reset in the middle of a multiply.
    issue(2'b10, 6'b011000, 32'hFFFFFFFD, 32'h7);
    tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {26'h0, in_ready, out_valid, operation, result},
        {26'h0, 1'b1, 1'b0, 4'b0000, 32'h0});
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("rst_mid_no_strobe", 64'(bad), 64'h0);
    read_hilo("rst_mid", 32'h0, 32'h0);

    // Flush partway through multu.
    issue(2'b10, 6'b011001, 32'hFFFFFFFF, 32'h2);
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_mul_ready", 64'(in_ready), 64'h1);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    chk("flush_mul_no_strobe", 64'(bad), 64'h0);
    read_hilo("flush_mul", 32'h0, 32'h0);

`ifdef ALU_DIV_EN
    long_op("div", 6'b011010, 32'hFFFFFFF9, 32'h2, 4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFD);
    long_op("divu0", 6'b011011, 32'h9, 32'h0, 4'b1001, 32'h00000009, 32'hFFFFFFFF);
    long_op("div_min", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 4'b1001, 32'h00000000, 32'h80000000);
    long_op("divu", 6'b011011, 32'd100, 32'd7, 4'b1001, 32'd2, 32'd14);
`else
    issue(2'b10, 6'b011010, 32'hFFFFFFF9, 32'h2);
    chk("div_off_strobe", {58'h0, in_ready, out_valid, out_wb, operation},
        {58'h0, 1'b1, 1'b1, 1'b0, 4'b1001});
    read_hilo("div_off", 32'h0, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
